// File: rtl/amiga_trigger_pkg.sv
// Shared types and helpers for the AMIGA trigger-link serializer.
package amiga_trigger_pkg;

  localparam int DEFAULT_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/amiga_trigger_serializer.sv
// Serializes one trigger word per handshake onto the AMIGA link, one bit per divided-clock period.
//   state | meaning
//   IDLE  | ready for a word, divider held off
//   SHIFT | divider running, one bit presented per div_clock period
//   LATCH | single-cycle latch strobe after the last bit
module amiga_trigger_serializer
  import amiga_trigger_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  div_enable,
  input  logic                  div_clock,
  output logic                  sdata,
  output logic                  latch,
  output logic                  busy
);

  localparam int            CW   = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic [CW-1:0]         rise_cnt;
  logic                  div_clock_d;
  logic                  rise, fall;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
  endfunction

  assign rise      = div_clock & ~div_clock_d;
  assign fall      = ~div_clock & div_clock_d;
  assign shift_nxt = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    div_enable = 1'b0;
    latch      = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        div_enable = 1'b1;
        if (fall && rise_cnt == LAST) state_nxt = LATCH;
      end
      LATCH: begin
        latch     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      shift_reg   <= '0;
      rise_cnt    <= '0;
      div_clock_d <= 1'b0;
      sdata       <= 1'b0;
    end else begin
      state       <= state_nxt;
      div_clock_d <= div_clock;
      case (state)
        IDLE: begin
          if (s_valid) begin
            shift_reg <= s_data;
            sdata     <= first_bit(s_data);
            rise_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (rise && rise_cnt != LAST) rise_cnt <= rise_cnt + 1'b1;
          // The word register is cleared on the final fall so nothing of s_data lingers into IDLE.
          if (fall) begin
            if (rise_cnt == LAST) begin
              shift_reg <= '0;
              sdata     <= 1'b0;
            end else begin
              shift_reg <= shift_nxt;
              sdata     <= first_bit(shift_nxt);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
